// File: rtl/clkloop_if.sv
// clkloop_if: error-word input, gain and filtered-output bundle for the loop-filter sequencer
interface clkloop_if;
    logic [15:0] tin;
    logic [15:0] fin;
    logic        iv;
    logic        clr;
    logic        frz;
    logic [3:0]  kpt;
    logic [3:0]  kit;
    logic [3:0]  kpf;
    logic [3:0]  kif;
    logic [15:0] tadj;
    logic [23:0] fadj;
    logic        ov;
    logic        busy;
    logic        ovr;
    modport master (
        output tin, fin, iv, clr, frz, kpt, kit, kpf, kif,
        input  tadj, fadj, ov, busy, ovr
    );
    modport slave (
        input  tin, fin, iv, clr, frz, kpt, kit, kpf, kif,
        output tadj, fadj, ov, busy, ovr
    );
endinterface

// File: rtl/clkloop.sv
// clkloop: timing and frequency PI loop filters sharing one saturating 24-bit adder
module clkloop (
    input logic     clk,
    input logic     rst,
    clkloop_if.slave lf
);
    typedef enum logic [2:0] {IDLE, TI, TO, FI, FO} state_t;
    state_t             state_q, state_d;
    logic signed [23:0] ti_q, ti_d, fi_q, fi_d;
    logic [15:0]        et_q, et_d, ef_q, ef_d;
    logic [15:0]        tv_q, tv_d;
    logic [15:0]        tadj_q, tadj_d;
    logic [23:0]        fadj_q, fadj_d;
    logic               ov_q, ov_d, ovr_q, ovr_d;
    logic               tsel;
    logic signed [23:0] add_a, add_s, add_y;
    logic [15:0]        add_e;
    logic [3:0]         add_k;
    logic signed [24:0] add_sum;
    // Shared adder: operands steered by state, result clamped to the 24-bit signed range
    always_comb begin
        tsel    = state_q == TI || state_q == TO;
        add_a   = tsel ? ti_q : fi_q;
        add_e   = tsel ? et_q : ef_q;
        add_k   = state_q == TI ? lf.kit : state_q == TO ? lf.kpt : state_q == FI ? lf.kif : lf.kpf;
        add_s   = $signed({add_e, 8'b0}) >>> add_k;
        add_sum = {add_a[23], add_a} + {add_s[23], add_s};
        add_y   = add_sum[24] != add_sum[23] ? (add_sum[24] ? 24'h800000 : 24'h7FFFFF) : add_sum[23:0];
    end
    // Sequencer: one adder operation per state, clr overrides integrator writes
    always_comb begin
        state_d = state_q;
        et_d    = et_q;
        ef_d    = ef_q;
        ti_d    = ti_q;
        fi_d    = fi_q;
        tv_d    = tv_q;
        tadj_d  = tadj_q;
        fadj_d  = fadj_q;
        ov_d    = 1'b0;
        ovr_d   = ovr_q | (lf.iv && state_q != IDLE);
        case (state_q)
            IDLE: if (lf.iv) begin
                et_d    = lf.tin;
                ef_d    = lf.fin;
                state_d = TI;
            end
            TI: begin
                ti_d    = lf.frz ? ti_q : add_y;
                state_d = TO;
            end
            TO: begin
                tv_d    = add_y[23:8];
                state_d = FI;
            end
            FI: begin
                fi_d    = lf.frz ? fi_q : add_y;
                state_d = FO;
            end
            FO: begin
                tadj_d  = tv_q;
                fadj_d  = add_y;
                ov_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (lf.clr) begin
            ti_d  = '0;
            fi_d  = '0;
            ovr_d = 1'b0;
        end
    end
    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            et_q    <= '0;
            ef_q    <= '0;
            ti_q    <= '0;
            fi_q    <= '0;
            tv_q    <= '0;
            tadj_q  <= '0;
            fadj_q  <= '0;
            ov_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            et_q    <= et_d;
            ef_q    <= ef_d;
            ti_q    <= ti_d;
            fi_q    <= fi_d;
            tv_q    <= tv_d;
            tadj_q  <= tadj_d;
            fadj_q  <= fadj_d;
            ov_q    <= ov_d;
            ovr_q   <= ovr_d;
        end
    end
    assign lf.tadj = tadj_q;
    assign lf.fadj = fadj_q;
    assign lf.ov   = ov_q;
    assign lf.busy = state_q != IDLE;
    assign lf.ovr  = ovr_q;
endmodule

// File: tb/tb_clkloop.sv
// tb_clkloop: directed and randomized checks of clkloop against an arithmetic PI-loop model
module tb_clkloop;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int ncmp = 0;
    int nerr = 0;
    longint mti = 0, mfi = 0;
    logic [15:0] etadj;
    logic [23:0] efadj;
    clkloop_if lf();
    clkloop dut (.clk(clk), .rst(rst), .lf(lf));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic longint sat24(input longint v);
        return v > 64'sd8388607 ? 64'sd8388607 : v < -64'sd8388608 ? -64'sd8388608 : v;
    endfunction
    function automatic longint term(input logic [15:0] e, input logic [3:0] k);
        longint x;
        x = longint'($signed(e)) * 256;
        return x >>> k;
    endfunction
    task automatic model(input logic [15:0] t, input logic [15:0] f);
        longint tv, fv;
        if (!lf.frz) mti = sat24(mti + term(t, lf.kit));
        tv = sat24(mti + term(t, lf.kpt));
        if (!lf.frz) mfi = sat24(mfi + term(f, lf.kif));
        fv = sat24(mfi + term(f, lf.kpf));
        etadj = 16'((tv & 64'hFFFFFF) >> 8);
        efadj = 24'(fv);
    endtask
    task automatic send(input logic [15:0] t, input logic [15:0] f);
        int lat;
        lf.tin = t;
        lf.fin = f;
        lf.iv  = 1'b1;
        step();
        lf.iv  = 1'b0;
        chk("busy", 32'(lf.busy), 1);
        lat = 1;
        while (!lf.ov && lat < 12) begin
            step();
            lat++;
        end
        model(t, f);
        chk("latency", lat, 5);
        chk("tadj", 32'(lf.tadj), 32'(etadj));
        chk("fadj", 32'(lf.fadj), 32'(efadj));
    endtask
    task automatic clear();
        lf.clr = 1'b1;
        step();
        lf.clr = 1'b0;
        mti = 0;
        mfi = 0;
    endtask
    initial begin
        lf.tin = '0; lf.fin = '0; lf.iv = 1'b0; lf.clr = 1'b0; lf.frz = 1'b0;
        lf.kit = 4'd8; lf.kpt = 4'd4; lf.kif = 4'd8; lf.kpf = 4'd4;
        step();
        step();
        rst = 1'b0;
        chk("rst_tadj", 32'(lf.tadj), 0);
        chk("rst_fadj", 32'(lf.fadj), 0);
        chk("rst_ov", 32'(lf.ov), 0);
        chk("rst_busy", 32'(lf.busy), 0);
        chk("rst_ovr", 32'(lf.ovr), 0);
        send(16'h0100, 16'h0000);
        chk("single_tadj", 32'(lf.tadj), 32'h0011);
        chk("single_fadj", 32'(lf.fadj), 32'h0);
        step();
        chk("ov_strobe", 32'(lf.ov), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            step();
            send(16'h0100, 16'h0000);
            chk("integ_tadj", 32'(lf.tadj), 32'h0012 + i);
        end
        clear();
        lf.kif = 4'd0;
        lf.kpf = 4'd0;
        for (int i = 0; i < 300; i++) send(16'h0000, 16'h7FFF);
        chk("sat_pos", 32'(lf.fadj), 32'h7FFFFF);
        clear();
        for (int i = 0; i < 300; i++) send(16'h0000, 16'h8000);
        chk("sat_neg", 32'(lf.fadj), 32'h800000);
        clear();
        lf.kif = 4'd8;
        lf.kpf = 4'd4;
        lf.tin = 16'h0100; lf.fin = 16'h0000; lf.iv = 1'b1;
        step();
        lf.iv = 1'b0;
        step();
        lf.tin = 16'h7000; lf.fin = 16'h1234; lf.iv = 1'b1;
        step();
        lf.iv = 1'b0;
        chk("ovr_no_ov", 32'(lf.ov), 0);
        step();
        lf.iv = 1'b1;
        step();
        lf.iv = 1'b0;
        model(16'h0100, 16'h0000);
        chk("ovr_ov", 32'(lf.ov), 1);
        chk("ovr_tadj", 32'(lf.tadj), 32'(etadj));
        chk("ovr_flag", 32'(lf.ovr), 1);
        step();
        chk("ovr_idle", 32'(lf.busy), 0);
        chk("ovr_single", 32'(lf.ov), 0);
        clear();
        chk("ovr_clr", 32'(lf.ovr), 0);
        send(16'h0100, 16'h0000);
        chk("clr_int", 32'(lf.tadj), 32'h0011);
        clear();
        lf.frz = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(16'h0100, 16'h0000);
            chk("frz_tadj", 32'(lf.tadj), 32'h0010);
        end
        lf.frz = 1'b0;
        send(16'h0100, 16'h0200);
        lf.tin = 16'h0300; lf.iv = 1'b1;
        step();
        lf.iv = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mti = 0;
        mfi = 0;
        chk("mid_busy", 32'(lf.busy), 0);
        chk("mid_tadj", 32'(lf.tadj), 0);
        chk("mid_fadj", 32'(lf.fadj), 0);
        chk("mid_ov", 32'(lf.ov), 0);
        step();
        chk("mid_no_ov", 32'(lf.ov), 0);
        send(16'h0100, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) clear();
            lf.kit = 4'($urandom_range(15));
            lf.kpt = 4'($urandom_range(15));
            lf.kif = 4'($urandom_range(15));
            lf.kpf = 4'($urandom_range(15));
            lf.frz = $urandom_range(3) == 0;
            send(16'($urandom), 16'($urandom));
            chk("rnd_ovr", 32'(lf.ovr), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
